// File: rtl/set_associative_replacement_unit_if.sv
// CPU-side and snoop-side request/response signals of the replacement unit.
// The master drives the requests and the slave returns the victim way.
interface set_associative_replacement_unit_if #(
    parameter int INDEX_WIDTH = 6,
    parameter int WAY_WIDTH   = 2
);
    logic [INDEX_WIDTH-1:0] cpuIndexIn;
    logic                   accessEnable;
    logic [WAY_WIDTH-1:0]   lastAccessedCacheLine;
    logic [INDEX_WIDTH-1:0] snoopyIndexIn;
    logic                   invalidateEnable;
    logic [WAY_WIDTH-1:0]   invalidatedCacheLine;
    logic [WAY_WIDTH-1:0]   replacementCacheLine;
    logic                   evictionRequired;

    modport master (
        output cpuIndexIn, accessEnable, lastAccessedCacheLine,
        output snoopyIndexIn, invalidateEnable, invalidatedCacheLine,
        input  replacementCacheLine, evictionRequired
    );

    modport slave (
        input  cpuIndexIn, accessEnable, lastAccessedCacheLine,
        input  snoopyIndexIn, invalidateEnable, invalidatedCacheLine,
        output replacementCacheLine, evictionRequired
    );
endinterface

// File: rtl/set_associative_replacement_unit.sv
// Per-set replacement state (true LRU ages or tree pseudo-LRU) with valid tracking.
// One CPU access and one snoop invalidate per cycle; same-set collisions resolve access-then-invalidate.
module set_associative_replacement_unit #(
    parameter int INDEX_WIDTH = 6,
    parameter int WAY_WIDTH   = 2,
    parameter int MODE        = 0
) (
    input logic clock,
    input logic reset,
    set_associative_replacement_unit_if.slave bus
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int WAYS = 1 << WAY_WIDTH;

    logic [WAYS-1:0]      validQ [SETS];
    logic [WAYS-1:0]      validAcc, validInvBase, validInv, curValid;
    logic                 sameSet, doAccess, anyInvalid;
    logic [WAY_WIDTH-1:0] firstInvalid, policyVictim;

    // A same-set, same-way collision keeps only the invalidate.
    assign sameSet  = bus.invalidateEnable && (bus.snoopyIndexIn == bus.cpuIndexIn);
    assign doAccess = bus.accessEnable &&
                      !(sameSet && (bus.invalidatedCacheLine == bus.lastAccessedCacheLine));

    always_comb begin
        validAcc = validQ[bus.cpuIndexIn];
        if (doAccess) validAcc[bus.lastAccessedCacheLine] = 1'b1;
        validInvBase = sameSet ? validAcc : validQ[bus.snoopyIndexIn];
        validInv = validInvBase;
        validInv[bus.invalidatedCacheLine] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            validQ <= '{default: '0};
        end else begin
            if (doAccess) validQ[bus.cpuIndexIn] <= validAcc;
            if (bus.invalidateEnable) validQ[bus.snoopyIndexIn] <= validInv;
        end
    end

    always_comb begin
        curValid     = validQ[bus.cpuIndexIn];
        anyInvalid   = 1'b0;
        firstInvalid = '0;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!curValid[WAY_WIDTH'(w - 1)]) begin
                anyInvalid   = 1'b1;
                firstInvalid = WAY_WIDTH'(w - 1);
            end
        end
    end

    assign bus.replacementCacheLine = anyInvalid ? firstInvalid : policyVictim;
    assign bus.evictionRequired     = !anyInvalid;

    if (MODE == 0) begin : gLru
        logic [WAY_WIDTH-1:0] ageQ [SETS][WAYS];
        logic [WAY_WIDTH-1:0] ageAcc [WAYS];
        logic [WAY_WIDTH-1:0] ageInvBase [WAYS];
        logic [WAY_WIDTH-1:0] ageInv [WAYS];
        logic [WAY_WIDTH-1:0] accAge, invAge;

        always_comb begin
            accAge = ageQ[bus.cpuIndexIn][bus.lastAccessedCacheLine];
            for (int unsigned w = 0; w < WAYS; w++) begin
                ageAcc[WAY_WIDTH'(w)] = ageQ[bus.cpuIndexIn][WAY_WIDTH'(w)];
                if (doAccess) begin
                    if (WAY_WIDTH'(w) == bus.lastAccessedCacheLine)
                        ageAcc[WAY_WIDTH'(w)] = '0;
                    else if (ageQ[bus.cpuIndexIn][WAY_WIDTH'(w)] < accAge)
                        ageAcc[WAY_WIDTH'(w)] = ageQ[bus.cpuIndexIn][WAY_WIDTH'(w)] + WAY_WIDTH'(1);
                end
            end
            for (int unsigned w = 0; w < WAYS; w++)
                ageInvBase[WAY_WIDTH'(w)] = sameSet ? ageAcc[WAY_WIDTH'(w)]
                                                    : ageQ[bus.snoopyIndexIn][WAY_WIDTH'(w)];
            invAge = ageInvBase[bus.invalidatedCacheLine];
            // Invalidated way becomes LRU; younger-than-it ways close the gap.
            for (int unsigned w = 0; w < WAYS; w++) begin
                ageInv[WAY_WIDTH'(w)] = ageInvBase[WAY_WIDTH'(w)];
                if (WAY_WIDTH'(w) == bus.invalidatedCacheLine)
                    ageInv[WAY_WIDTH'(w)] = '1;
                else if (ageInvBase[WAY_WIDTH'(w)] > invAge)
                    ageInv[WAY_WIDTH'(w)] = ageInvBase[WAY_WIDTH'(w)] - WAY_WIDTH'(1);
            end
        end

        always_comb begin
            policyVictim = '0;
            for (int unsigned w = 0; w < WAYS; w++)
                if (ageQ[bus.cpuIndexIn][WAY_WIDTH'(w)] == '1) policyVictim = WAY_WIDTH'(w);
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int unsigned s = 0; s < SETS; s++)
                    for (int unsigned w = 0; w < WAYS; w++)
                        ageQ[INDEX_WIDTH'(s)][WAY_WIDTH'(w)] <= WAY_WIDTH'(w);
            end else begin
                if (doAccess)
                    for (int unsigned w = 0; w < WAYS; w++)
                        ageQ[bus.cpuIndexIn][WAY_WIDTH'(w)] <= ageAcc[WAY_WIDTH'(w)];
                if (bus.invalidateEnable)
                    for (int unsigned w = 0; w < WAYS; w++)
                        ageQ[bus.snoopyIndexIn][WAY_WIDTH'(w)] <= ageInv[WAY_WIDTH'(w)];
            end
        end
    end else begin : gPlru
        logic [WAYS-2:0]      treeQ [SETS];
        logic [WAYS-2:0]      treeAcc, treeInvBase, treeInv, curTree;
        logic [WAY_WIDTH-1:0] nodeA, nodeI, nodeV, pathA, pathI;

        // Paths are walked MSB-first; the next node is 2n+1 for a 0 branch, 2n+2 for a 1 branch.
        always_comb begin
            treeAcc = treeQ[bus.cpuIndexIn];
            nodeA   = '0;
            pathA   = bus.lastAccessedCacheLine;
            for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
                if (doAccess) treeAcc[nodeA] = ~pathA[WAY_WIDTH-1];
                nodeA = WAY_WIDTH'({nodeA, 1'b1} + {{WAY_WIDTH{1'b0}}, pathA[WAY_WIDTH-1]});
                pathA = pathA << 1;
            end
            treeInvBase = sameSet ? treeAcc : treeQ[bus.snoopyIndexIn];
            treeInv     = treeInvBase;
            nodeI       = '0;
            pathI       = bus.invalidatedCacheLine;
            for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
                treeInv[nodeI] = pathI[WAY_WIDTH-1];
                nodeI = WAY_WIDTH'({nodeI, 1'b1} + {{WAY_WIDTH{1'b0}}, pathI[WAY_WIDTH-1]});
                pathI = pathI << 1;
            end
        end

        always_comb begin
            curTree      = treeQ[bus.cpuIndexIn];
            nodeV        = '0;
            policyVictim = '0;
            for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
                policyVictim = WAY_WIDTH'({policyVictim, curTree[nodeV]});
                nodeV = WAY_WIDTH'({nodeV, 1'b1} + {{WAY_WIDTH{1'b0}}, curTree[nodeV]});
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                treeQ <= '{default: '0};
            end else begin
                if (doAccess) treeQ[bus.cpuIndexIn] <= treeAcc;
                if (bus.invalidateEnable) treeQ[bus.snoopyIndexIn] <= treeInv;
            end
        end
    end
endmodule

// File: tb/tb_set_associative_replacement_unit.sv
// Directed bench: true-LRU and 4-way pseudo-LRU instances plus a 2-way pseudo-LRU instance.
// Expected victims are hand-derived from the age/tree update rules.
module tb_set_associative_replacement_unit;
    logic clock;
    logic reset;
    int   assertions;
    int   failures;

    set_associative_replacement_unit_if #(.INDEX_WIDTH(6), .WAY_WIDTH(2)) bus0 ();
    set_associative_replacement_unit_if #(.INDEX_WIDTH(6), .WAY_WIDTH(2)) bus1 ();
    set_associative_replacement_unit_if #(.INDEX_WIDTH(2), .WAY_WIDTH(1)) bus2 ();

    set_associative_replacement_unit #(.INDEX_WIDTH(6), .WAY_WIDTH(2), .MODE(0)) uLru (
        .clock(clock), .reset(reset), .bus(bus0));
    set_associative_replacement_unit #(.INDEX_WIDTH(6), .WAY_WIDTH(2), .MODE(1)) uPlru (
        .clock(clock), .reset(reset), .bus(bus1));
    set_associative_replacement_unit #(.INDEX_WIDTH(2), .WAY_WIDTH(1), .MODE(1)) uNarrow (
        .clock(clock), .reset(reset), .bus(bus2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive0(input logic acc, input int cIdx, input int cWay,
                          input logic inv, input int sIdx, input int sWay);
        bus0.accessEnable = acc; bus0.cpuIndexIn = 6'(cIdx); bus0.lastAccessedCacheLine = 2'(cWay);
        bus0.invalidateEnable = inv; bus0.snoopyIndexIn = 6'(sIdx); bus0.invalidatedCacheLine = 2'(sWay);
        @(posedge clock); #1;
        bus0.accessEnable = 1'b0; bus0.invalidateEnable = 1'b0;
    endtask

    task automatic drive1(input logic acc, input int cIdx, input int cWay,
                          input logic inv, input int sIdx, input int sWay);
        bus1.accessEnable = acc; bus1.cpuIndexIn = 6'(cIdx); bus1.lastAccessedCacheLine = 2'(cWay);
        bus1.invalidateEnable = inv; bus1.snoopyIndexIn = 6'(sIdx); bus1.invalidatedCacheLine = 2'(sWay);
        @(posedge clock); #1;
        bus1.accessEnable = 1'b0; bus1.invalidateEnable = 1'b0;
    endtask

    task automatic drive2(input logic acc, input int cWay, input logic inv, input int sWay);
        bus2.accessEnable = acc; bus2.cpuIndexIn = 2'd1; bus2.lastAccessedCacheLine = 1'(cWay);
        bus2.invalidateEnable = inv; bus2.snoopyIndexIn = 2'd1; bus2.invalidatedCacheLine = 1'(sWay);
        @(posedge clock); #1;
        bus2.accessEnable = 1'b0; bus2.invalidateEnable = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) begin
            bus0.cpuIndexIn = 6'(i); bus1.cpuIndexIn = 6'(i); #1;
            assertions++;
            if (bus0.replacementCacheLine !== 2'd0 || bus0.evictionRequired !== 1'b0) begin
                failures++;
                $display("FAIL reset_lru idx=%0d victim=%0d evict=%0b required victim=0 evict=0",
                         i, bus0.replacementCacheLine, bus0.evictionRequired);
            end
            assertions++;
            if (bus1.replacementCacheLine !== 2'd0 || bus1.evictionRequired !== 1'b0) begin
                failures++;
                $display("FAIL reset_plru idx=%0d victim=%0d evict=%0b required victim=0 evict=0",
                         i, bus1.replacementCacheLine, bus1.evictionRequired);
            end
        end
    endtask

    task automatic test_lru_access();
        for (int w = 0; w < 4; w++) drive0(1'b1, 1, w, 1'b0, 0, 0);
        bus0.cpuIndexIn = 6'd1; #1;
        assertions++;
        if (bus0.replacementCacheLine !== 2'd0 || bus0.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL lru_fill victim=%0d evict=%0b required victim=0 evict=1",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        drive0(1'b1, 1, 0, 1'b0, 0, 0);
        assertions++;
        if (bus0.replacementCacheLine !== 2'd1 || bus0.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL lru_reaccess victim=%0d evict=%0b required victim=1 evict=1",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
    endtask

    task automatic test_lru_invalidate();
        drive0(1'b0, 1, 0, 1'b1, 1, 2);
        bus0.cpuIndexIn = 6'd1; #1;
        assertions++;
        if (bus0.replacementCacheLine !== 2'd2 || bus0.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL lru_invalidate victim=%0d evict=%0b required victim=2 evict=0",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        bus0.cpuIndexIn = 6'd2; #1;
        assertions++;
        if (bus0.replacementCacheLine !== 2'd0 || bus0.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL lru_other_set victim=%0d evict=%0b required victim=0 evict=0",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
    endtask

    task automatic test_collision();
        for (int w = 0; w < 4; w++) drive0(1'b1, 5, w, 1'b0, 0, 0);
        drive0(1'b1, 5, 3, 1'b1, 5, 3);
        assertions++;
        if (bus0.replacementCacheLine !== 2'd3 || bus0.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL collide_same_way victim=%0d evict=%0b required victim=3 evict=0",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        // Ages go [2,1,0,3] -> [3,2,1,0] after re-touching every way in order.
        for (int w = 0; w < 4; w++) drive0(1'b1, 5, w, 1'b0, 0, 0);
        assertions++;
        if (bus0.replacementCacheLine !== 2'd0 || bus0.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL collide_refill victim=%0d evict=%0b required victim=0 evict=1",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        drive0(1'b1, 5, 0, 1'b1, 5, 1);
        assertions++;
        if (bus0.replacementCacheLine !== 2'd1 || bus0.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL collide_diff_way victim=%0d evict=%0b required victim=1 evict=0",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        drive0(1'b1, 5, 1, 1'b0, 0, 0);
        assertions++;
        if (bus0.replacementCacheLine !== 2'd2 || bus0.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL collide_ages victim=%0d evict=%0b required victim=2 evict=1",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
    endtask

    task automatic test_back_to_back();
        drive0(1'b1, 8, 0, 1'b1, 5, 2);
        bus0.cpuIndexIn = 6'd5; #1;
        assertions++;
        if (bus0.replacementCacheLine !== 2'd2 || bus0.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL split_snoop_set victim=%0d evict=%0b required victim=2 evict=0",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        bus0.cpuIndexIn = 6'd8; #1;
        assertions++;
        if (bus0.replacementCacheLine !== 2'd1 || bus0.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL split_cpu_set victim=%0d evict=%0b required victim=1 evict=0",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        drive0(1'b1, 8, 0, 1'b0, 0, 0);
        for (int w = 1; w < 4; w++) drive0(1'b1, 8, w, 1'b0, 0, 0);
        assertions++;
        if (bus0.replacementCacheLine !== 2'd0 || bus0.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL mru_repeat victim=%0d evict=%0b required victim=0 evict=1",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
    endtask

    task automatic test_plru();
        for (int w = 0; w < 4; w++) drive1(1'b1, 0, w, 1'b0, 0, 0);
        assertions++;
        if (bus1.replacementCacheLine !== 2'd0 || bus1.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL plru_fill victim=%0d evict=%0b required victim=0 evict=1",
                     bus1.replacementCacheLine, bus1.evictionRequired);
        end
        drive1(1'b1, 0, 0, 1'b0, 0, 0);
        assertions++;
        if (bus1.replacementCacheLine !== 2'd2 || bus1.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL plru_reaccess victim=%0d evict=%0b required victim=2 evict=1",
                     bus1.replacementCacheLine, bus1.evictionRequired);
        end
        drive1(1'b0, 0, 0, 1'b1, 0, 1);
        assertions++;
        if (bus1.replacementCacheLine !== 2'd1 || bus1.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL plru_invalidate victim=%0d evict=%0b required victim=1 evict=0",
                     bus1.replacementCacheLine, bus1.evictionRequired);
        end
        for (int w = 0; w < 4; w++) drive1(1'b1, 4, w, 1'b0, 0, 0);
        drive1(1'b1, 4, 0, 1'b1, 4, 3);
        assertions++;
        if (bus1.replacementCacheLine !== 2'd3 || bus1.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL plru_collide victim=%0d evict=%0b required victim=3 evict=0",
                     bus1.replacementCacheLine, bus1.evictionRequired);
        end
        drive1(1'b1, 4, 3, 1'b0, 0, 0);
        assertions++;
        if (bus1.replacementCacheLine !== 2'd1 || bus1.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL plru_collide_walk victim=%0d evict=%0b required victim=1 evict=1",
                     bus1.replacementCacheLine, bus1.evictionRequired);
        end
    endtask

    task automatic test_narrow();
        logic [1:0] expVictim [4];
        logic       expEvict [4];
        logic       acc [4];
        int         way [4];
        acc = '{1'b1, 1'b1, 1'b1, 1'b0};
        way = '{0, 1, 0, 0};
        expVictim = '{2'd1, 2'd0, 2'd1, 2'd0};
        expEvict  = '{1'b0, 1'b1, 1'b1, 1'b0};
        bus2.cpuIndexIn = 2'd1; #1;
        assertions++;
        if (bus2.replacementCacheLine !== 1'b0 || bus2.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL narrow_reset victim=%0d evict=%0b required victim=0 evict=0",
                     bus2.replacementCacheLine, bus2.evictionRequired);
        end
        for (int i = 0; i < 4; i++) begin
            drive2(acc[i], way[i], !acc[i], way[i]);
            assertions++;
            if (bus2.replacementCacheLine !== expVictim[i][0] || bus2.evictionRequired !== expEvict[i]) begin
                failures++;
                $display("FAIL narrow_step%0d victim=%0d evict=%0b required victim=%0d evict=%0b",
                         i, bus2.replacementCacheLine, bus2.evictionRequired, expVictim[i][0], expEvict[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int w = 0; w < 4; w++) drive0(1'b1, 9, w, 1'b0, 0, 0);
        drive1(1'b1, 0, 1, 1'b0, 0, 0);
        assertions++;
        if (bus1.replacementCacheLine !== 2'd2 || bus1.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL prereset_plru victim=%0d evict=%0b required victim=2 evict=1",
                     bus1.replacementCacheLine, bus1.evictionRequired);
        end
        bus0.cpuIndexIn = 6'd9; bus0.lastAccessedCacheLine = 2'd0; bus0.accessEnable = 1'b1;
        bus1.cpuIndexIn = 6'd0; bus1.lastAccessedCacheLine = 2'd3; bus1.accessEnable = 1'b1;
        #3 reset = 1'b0;
        #1;
        assertions++;
        if (bus0.replacementCacheLine !== 2'd0 || bus0.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_lru victim=%0d evict=%0b required victim=0 evict=0",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        assertions++;
        if (bus1.replacementCacheLine !== 2'd0 || bus1.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_plru victim=%0d evict=%0b required victim=0 evict=0",
                     bus1.replacementCacheLine, bus1.evictionRequired);
        end
        @(posedge clock); #2;
        bus0.accessEnable = 1'b0; bus1.accessEnable = 1'b0;
        #1 reset = 1'b1;
        #1;
        assertions++;
        if (bus0.replacementCacheLine !== 2'd0 || bus0.evictionRequired !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_enable victim=%0d evict=%0b required victim=0 evict=0",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
        // From reset ages [0,1,2,3], touching 3,2,1,0 leaves way 3 oldest.
        for (int w = 3; w >= 0; w--) drive0(1'b1, 9, w, 1'b0, 0, 0);
        assertions++;
        if (bus0.replacementCacheLine !== 2'd3 || bus0.evictionRequired !== 1'b1) begin
            failures++;
            $display("FAIL reset_ages victim=%0d evict=%0b required victim=3 evict=1",
                     bus0.replacementCacheLine, bus0.evictionRequired);
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        reset      = 1'b0;
        bus0.cpuIndexIn = '0; bus0.accessEnable = 1'b0; bus0.lastAccessedCacheLine = '0;
        bus0.snoopyIndexIn = '0; bus0.invalidateEnable = 1'b0; bus0.invalidatedCacheLine = '0;
        bus1.cpuIndexIn = '0; bus1.accessEnable = 1'b0; bus1.lastAccessedCacheLine = '0;
        bus1.snoopyIndexIn = '0; bus1.invalidateEnable = 1'b0; bus1.invalidatedCacheLine = '0;
        bus2.cpuIndexIn = '0; bus2.accessEnable = 1'b0; bus2.lastAccessedCacheLine = '0;
        bus2.snoopyIndexIn = '0; bus2.invalidateEnable = 1'b0; bus2.invalidatedCacheLine = '0;
        #12 reset = 1'b1;
        test_reset();
        test_lru_access();
        test_lru_invalidate();
        test_collision();
        test_back_to_back();
        test_plru();
        test_narrow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/set_associative_replacement_unit.md
Name: set_associative_replacement_unit

Overview:
Per-set replacement-state engine for an N-way set-associative cache, parametrised in set count and associativity. Selectable policy: true LRU (age counters) or tree pseudo-LRU. Tracks per-way valid bits so invalid ways are always victimised first. Serves one CPU port (access/victim lookup) and one snoop port (invalidate) per cycle, with a defined resolution for same-set collisions.

Parameters:
INDEX_WIDTH, 6, set index width; SETS = 2^INDEX_WIDTH
WAY_WIDTH, 2, way index width; WAYS = 2^WAY_WIDTH; legal range 1..4
MODE, 0, 0 = true LRU, 1 = tree pseudo-LRU

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
cpuIndexIn  input  INDEX_WIDTH  set addressed by CPU port; also selects the victim output
accessEnable  input  1  record access to lastAccessedCacheLine in set cpuIndexIn
lastAccessedCacheLine  input  WAY_WIDTH  way hit or filled by CPU
snoopyIndexIn  input  INDEX_WIDTH  set addressed by snoop port
invalidateEnable  input  1  invalidate invalidatedCacheLine in set snoopyIndexIn
invalidatedCacheLine  input  WAY_WIDTH  way invalidated by snoop
replacementCacheLine  output  WAY_WIDTH  victim way for set cpuIndexIn
evictionRequired  output  1  1 = victim way is valid (writeback/evict needed)

Behaviour:
- State per set: valid[WAYS]; MODE 0: age[WAYS] of WAY_WIDTH bits (0 = MRU, WAYS-1 = LRU); MODE 1: WAYS-1 tree bits (bit 0 = root, children of node n at 2n+1 / 2n+2; bit 0 = victim in lower half).
- Reset (reset low, async, independent of clock): all valid = 0; age[w] = w in every set; all tree bits = 0. Outputs combinational from state, so after reset replacementCacheLine = 0, evictionRequired = 0 for any index.
- Victim select (combinational, zero latency from cpuIndexIn/state): lowest-numbered invalid way if any, evictionRequired = 0; otherwise MODE 0 the way with age = WAYS-1, MODE 1 the leaf reached by walking tree bits; evictionRequired = 1.
- Updates commit on the clock edge where the enable is high; the victim output reflects them from the following cycle. Enables low: state holds.
- Access way a (MODE 0): every way with age < age[a] increments; age[a] = 0. Access (MODE 1): every node on the path to a is set to point away from a. valid[a] = 1.
- Invalidate way v (MODE 0): every way with age > age[v] decrements; age[v] = WAYS-1. Invalidate (MODE 1): every node on the path to v is set to point toward v. valid[v] = 0.
- Age vector stays a permutation of 0..WAYS-1 at all times.
- Different sets in the same cycle: both updates apply independently.
- Same set, different ways: next state = invalidate applied to the post-access state (access first, then invalidate), single cycle.
- Same set, same way: invalidate only; access is dropped.
- Repeated access to the MRU way: no age change (MODE 0); tree bits rewritten to identical values (MODE 1).
- WAY_WIDTH = 1: one tree bit / 1-bit ages; the rules above hold unchanged.
- Reset asserted mid-operation: any update in flight is discarded; state returns to reset values immediately.

Test Plan:
1. MODE 0, after reset, cpuIndexIn = 3 -> replacementCacheLine = 0, evictionRequired = 0; the same holds for every index.
2. MODE 0, set 1: access ways 0, 1, 2, 3 on consecutive cycles -> ages [3,2,1,0], victim 0, evictionRequired = 1. Then access way 0 -> ages [0,3,2,1], victim 1.
3. Continuing from 2: invalidate set 1 way 2 -> ages [0,2,3,1], victim 2, evictionRequired = 0. Set 2 is unaffected (victim 0, evictionRequired = 0).
4. Collision, MODE 0, set 1 full with ages [3,2,1,0]: in the same cycle access way 3 and invalidate way 3 -> way 3 invalid, ages [2,1,0,3], victim 3, evictionRequired = 0. Same-cycle access way 0 plus invalidate way 1 -> ages [0,3,2,1] with way 1 invalid, victim 1.
5. MODE 1, WAYS = 4, set 0: access 0, 1, 2, 3 -> victim 0, evictionRequired = 1. Then access 0 -> victim 2. Then invalidate way 1 -> victim 1, evictionRequired = 0.
6. Drop reset low between clock edges with populated sets -> victim 0 and evictionRequired = 0 immediately. An enable held high across the reset edge has no effect on state.
